bus_arbiter_mux: RTL and testbench

- Parametrised N-master bus arbiter plus master-to-slave multiplexer.
- Successor to the fixed 4-master, externally-granted bus mux.
- Owns the request/grant handshake with a registered grant, bus hold until release, and direct hand-over.
- Sits between the CPU/DMA/debug bus masters and the shared slave address decoder.

---
 rtl/bus_arbiter_mux.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux.sv
// N-master bus arbiter with registered grant, hold-until-release, direct hand-over and slave-side mux.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (master 0 highest).
module bus_arbiter_mux #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned OWNER_W     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_req_,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_asel_,
    input  logic [NUM_MASTERS-1:0]        m_rw,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]        m_grnt_,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_asel_,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_wr_data,
    output logic                          bus_busy,
    output logic [OWNER_W-1:0]            owner_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                   state, state_n;
    logic [NUM_MASTERS-1:0]   grant_r, grant_n;
    logic [OWNER_W-1:0]       owner_r, owner_n;
    logic [NUM_MASTERS-1:0]   req, cand, scan, win_oh;
    logic                     found, owner_held;
    logic [OWNER_W-1:0]       off, win_id, win_next;
    logic [OWNER_W:0]         sum, inc;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [OWNER_W-1:0]       ptr_r, ptr_n;
`endif

    // The released owner is masked out so it cannot win the hand-over it just gave up.
    always_comb begin
        req  = ~m_req_;
        cand = req & ~grant_r;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        scan = NUM_MASTERS'({cand, cand} >> ptr_r);
`else
        scan = cand;
`endif
        found = 1'b0;
        off   = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (!found && scan[k]) begin
                found = 1'b1;
                off   = OWNER_W'(k);
            end
        end
`ifdef BUS_ARB_ROUND_ROBIN_EN
        sum = {1'b0, ptr_r} + {1'b0, off};
`else
        sum = {1'b0, off};
`endif
        if (sum >= (OWNER_W+1)'(NUM_MASTERS))
            sum = sum - (OWNER_W+1)'(NUM_MASTERS);
        win_id = sum[OWNER_W-1:0];
        win_oh = NUM_MASTERS'(1) << win_id;
        inc    = {1'b0, win_id} + 1'b1;
        if (inc == (OWNER_W+1)'(NUM_MASTERS))
            inc = '0;
        win_next   = inc[OWNER_W-1:0];
        owner_held = |(req & grant_r);
    end

    always_comb begin
        state_n = state;
        grant_n = grant_r;
        owner_n = owner_r;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        ptr_n   = ptr_r;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    grant_n = win_oh;
                    owner_n = win_id;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    ptr_n   = win_next;
`endif
                end
            end
            GRANT: begin
                if (!owner_held) begin
                    if (found) begin
                        grant_n = win_oh;
                        owner_n = win_id;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                        ptr_n   = win_next;
`endif
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_r <= '0;
            owner_r <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            ptr_r   <= '0;
`endif
        end else begin
            state   <= state_n;
            grant_r <= grant_n;
            owner_r <= owner_n;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            ptr_r   <= ptr_n;
`endif
        end
    end

    always_comb begin
        s_addr    = '0;
        s_asel_   = 1'b1;
        s_rw      = 1'b1;
        s_wr_data = '0;
        if (state == GRANT) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (owner_r == OWNER_W'(i)) begin
                    s_addr    = m_addr[i*ADDR_W +: ADDR_W];
                    s_asel_   = m_asel_[i];
                    s_rw      = m_rw[i];
                    s_wr_data = m_wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign m_grnt_  = ~grant_r;
    assign bus_busy = (state == GRANT);
    assign owner_id = owner_r;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Testbench for bus_arbiter_mux: constant vector table, async-reset sequence, and random traffic
// against a behavioural arbitration model (honours BUS_ARB_ROUND_ROBIN_EN).
module tb_bus_arbiter_mux;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int OW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_req_, m_asel_, m_rw;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wr_data;
    logic [N-1:0]    m_grnt_;
    logic [AW-1:0]   s_addr;
    logic            s_asel_, s_rw, bus_busy;
    logic [DW-1:0]   s_wr_data;
    logic [OW-1:0]   owner_id;

    logic [AW-1:0]   addr_a [N];
    logic [DW-1:0]   data_a [N];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // behavioural model state
    bit md_busy;
    int md_owner;
    int md_ptr;

    bus_arbiter_mux #(
        .NUM_MASTERS(N),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .OWNER_W    (OW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_req_   (m_req_),
        .m_addr   (m_addr),
        .m_asel_  (m_asel_),
        .m_rw     (m_rw),
        .m_wr_data(m_wr_data),
        .m_grnt_  (m_grnt_),
        .s_addr   (s_addr),
        .s_asel_  (s_asel_),
        .s_rw     (s_rw),
        .s_wr_data(s_wr_data),
        .bus_busy (bus_busy),
        .owner_id (owner_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]    = addr_a[i];
            m_wr_data[i*DW +: DW] = data_a[i];
        end
    end

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grnt;
        int           owner;
        bit           busy;
    } vec_t;

    vec_t tab [15];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] req);
        int start;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        start = md_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++)
            if (req[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        md_busy  = 1'b0;
        md_owner = 0;
        md_ptr   = 0;
    endtask

    // Applies the arbitration rules to the inputs present before the coming edge.
    task automatic model_step();
        logic [N-1:0] req;
        int w;
        req = ~m_req_;
        if (!(md_busy && req[md_owner])) begin
            w = pick(req);
            if (w >= 0) begin
                md_busy  = 1'b1;
                md_owner = w;
                md_ptr   = (w + 1) % N;
            end else begin
                md_busy = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        logic [N-1:0] eg;
        eg = md_busy ? ~(N'(1) << md_owner) : '1;
        chk("grant", m_grnt_, eg);
        chk("busy", bus_busy, md_busy);
        chk("owner", owner_id, md_owner);
        chk("s_addr", s_addr, md_busy ? addr_a[md_owner] : '0);
        chk("s_asel", s_asel_, md_busy ? m_asel_[md_owner] : 1'b1);
        chk("s_rw", s_rw, md_busy ? m_rw[md_owner] : 1'b1);
        chk("s_wr_data", s_wr_data, md_busy ? data_a[md_owner] : '0);
    endtask

    initial begin
        tab[0]  = '{4'b1111, 4'b1111, 0, 1'b0};
        tab[1]  = '{4'b1101, 4'b1101, 1, 1'b1};
        tab[2]  = '{4'b0101, 4'b1101, 1, 1'b1};
        tab[3]  = '{4'b0101, 4'b1101, 1, 1'b1};
        tab[4]  = '{4'b0111, 4'b0111, 3, 1'b1};
        tab[5]  = '{4'b0111, 4'b0111, 3, 1'b1};
        tab[6]  = '{4'b1111, 4'b1111, 3, 1'b0};
        tab[7]  = '{4'b1011, 4'b1011, 2, 1'b1};
        tab[8]  = '{4'b1111, 4'b1111, 2, 1'b0};
`ifdef BUS_ARB_ROUND_ROBIN_EN
        tab[9]  = '{4'b0000, 4'b0111, 3, 1'b1};
        tab[10] = '{4'b0000, 4'b0111, 3, 1'b1};
        tab[11] = '{4'b1000, 4'b1110, 0, 1'b1};
        tab[12] = '{4'b1000, 4'b1110, 0, 1'b1};
        tab[13] = '{4'b1001, 4'b1101, 1, 1'b1};
        tab[14] = '{4'b1111, 4'b1111, 1, 1'b0};
`else
        tab[9]  = '{4'b0000, 4'b1110, 0, 1'b1};
        tab[10] = '{4'b0000, 4'b1110, 0, 1'b1};
        tab[11] = '{4'b0001, 4'b1101, 1, 1'b1};
        tab[12] = '{4'b0000, 4'b1101, 1, 1'b1};
        tab[13] = '{4'b0010, 4'b1110, 0, 1'b1};
        tab[14] = '{4'b1111, 4'b1111, 0, 1'b0};
`endif

        addr_a[0] = 30'h0A5A5A5;  data_a[0] = 32'h1111_0000;
        addr_a[1] = 30'h0000100;  data_a[1] = 32'h2222_0001;
        addr_a[2] = 30'h0200200;  data_a[2] = 32'h3333_0002;
        addr_a[3] = 30'h3FFFFFF;  data_a[3] = 32'h4444_0003;
        m_asel_ = '0;
        m_rw    = 4'b0101;
        m_req_  = '1;

        // reset then idle
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_grant", m_grnt_, 4'b1111);
        chk("rst_asel", s_asel_, 1'b1);
        chk("rst_rw", s_rw, 1'b1);
        chk("rst_addr", s_addr, 0);
        chk("rst_data", s_wr_data, 0);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_owner", owner_id, 0);
        reset = 1'b0;

        for (int r = 0; r < 15; r++) begin
            m_req_ = tab[r].req;
            tick();
            chk("tab_grant", m_grnt_, tab[r].grnt);
            chk("tab_owner", owner_id, tab[r].owner);
            chk("tab_busy", bus_busy, tab[r].busy);
            chk("tab_addr", s_addr, tab[r].busy ? addr_a[tab[r].owner] : '0);
            chk("tab_asel", s_asel_, tab[r].busy ? 1'b0 : 1'b1);
        end

        // async reset while master 3 drives a write
        m_req_ = 4'b0111;
        tick();
        chk("ar_grant", m_grnt_, 4'b0111);
        chk("ar_rw_before", s_rw, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_grant_now", m_grnt_, 4'b1111);
        chk("ar_rw_now", s_rw, 1'b1);
        chk("ar_busy_now", bus_busy, 1'b0);
        chk("ar_owner_now", owner_id, 0);
        tick();
        reset  = 1'b0;
        m_req_ = 4'b1111;
        tick();
        chk("ar_idle", m_grnt_, 4'b1111);
        m_req_ = 4'b1011;
        #1;
        chk("ar_latency", m_grnt_, 4'b1111);
        tick();
        chk("ar_first_grant", m_grnt_, 4'b1011);
        chk("ar_first_owner", owner_id, 2);

        // random traffic against the model
        reset  = 1'b1;
        m_req_ = '1;
        tick();
        reset = 1'b0;
        model_reset();
        check_model();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) m_req_[i] = ~m_req_[i];
                addr_a[i] = AW'($urandom);
                data_a[i] = $urandom;
            end
            m_asel_ = N'($urandom);
            m_rw    = N'($urandom);
            model_step();
            tick();
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
